// File: rtl/dvs_aer_transmitter.sv
// dvs_aer_transmitter: DVS-side AER sender for loopback and self-test builds.
// Takes pixel events on a valid/ready port and sends each one as an optional
// Y-address word followed by an X-address word. Each word uses a 4-phase
// REQ/ACK handshake on a 10-bit bus.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ev_valid/ev_ready           event handshake (accept on valid && ready)
//   ev_x, ev_y, ev_polarity     event payload, latched on accept
//   aer[9:0], xsel              AER word (xsel 0 = Y word, 1 = X word)
//   req / ack                   AER handshake; ack is asynchronous
//   busy                        high whenever the sender is not idle
module dvs_aer_transmitter #(
  parameter int unsigned DVS_X_ADDR_BITS    = 9,
  parameter int unsigned DVS_Y_ADDR_BITS    = 9,
  parameter int unsigned MIN_EVENT_CYCLES   = 9,
  parameter int unsigned SETUP_CYCLES       = 1,
  parameter int unsigned ROW_TIMEOUT_CYCLES = 100
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ev_valid,
  output logic                       ev_ready,
  input  logic [DVS_X_ADDR_BITS-1:0] ev_x,
  input  logic [DVS_Y_ADDR_BITS-1:0] ev_y,
  input  logic                       ev_polarity,
  output logic [9:0]                 aer,
  output logic                       xsel,
  output logic                       req,
  input  logic                       ack,
  output logic                       busy
);

  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned AER_W     = 10;
  localparam int unsigned PACE_N    = (MIN_EVENT_CYCLES > 0) ? MIN_EVENT_CYCLES : 1;
  localparam int unsigned PACE_W    = $clog2(PACE_N + 1);
  // The accept edge after the PACE -> IDLE edge must be at least PACE_N cycles
  // after the previous accept, so PACE may leave once PACE_N-1 cycles have gone by.
  localparam int unsigned PACE_EXIT = PACE_N - 1;
  localparam int unsigned SETUP_N   = (SETUP_CYCLES > 0) ? SETUP_CYCLES : 1;
  localparam int unsigned SETUP_W   = $clog2(SETUP_N + 1);
  localparam int unsigned IDLE_N    = (ROW_TIMEOUT_CYCLES > 0) ? ROW_TIMEOUT_CYCLES : 1;
  localparam int unsigned IDLE_W    = $clog2(IDLE_N + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_Y_SETUP = 3'd1,
    ST_Y_REQ   = 3'd2,
    ST_Y_REL   = 3'd3,
    ST_X_SETUP = 3'd4,
    ST_X_REQ   = 3'd5,
    ST_X_REL   = 3'd6,
    ST_PACE    = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [AER_W-1:0]    aer_q, aer_d;
  logic                xsel_q, xsel_d;
  logic                req_q, req_d;
  logic                ev_ready_q, ev_ready_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   x_q, x_d;
  logic [ADDR_W-1:0]   y_q, y_d;
  logic                pol_q, pol_d;
  logic [ADDR_W-1:0]   last_y_q, last_y_d;
  logic                row_valid_q, row_valid_d;
  logic [SETUP_W-1:0]  setup_cnt_q, setup_cnt_d;
  logic [PACE_W-1:0]   pace_cnt_q, pace_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                ack_meta_q, ack_s_q;

  logic                accept_c;
  logic [ADDR_W-1:0]   ev_x_ext_c;
  logic [ADDR_W-1:0]   ev_y_ext_c;

  assign ev_x_ext_c = ADDR_W'(ev_x);
  assign ev_y_ext_c = ADDR_W'(ev_y);
  // ev_ready_q is only ever high while the FSM sits in IDLE.
  assign accept_c   = (state_q == ST_IDLE) && ev_valid && ev_ready_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    aer_d       = aer_q;
    xsel_d      = xsel_q;
    req_d       = req_q;
    x_d         = x_q;
    y_d         = y_q;
    pol_d       = pol_q;
    last_y_d    = last_y_q;
    row_valid_d = row_valid_q;
    setup_cnt_d = setup_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    pace_cnt_d  = (pace_cnt_q < PACE_W'(PACE_EXIT)) ? pace_cnt_q + PACE_W'(1) : pace_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          x_d         = ev_x_ext_c;
          y_d         = ev_y_ext_c;
          pol_d       = ev_polarity;
          setup_cnt_d = '0;
          idle_cnt_d  = '0;
          pace_cnt_d  = PACE_W'(1);
          // The latches load on this same edge, so the first word is formed
          // from the event fields being captured.
          if (row_valid_q && (ev_y_ext_c == last_y_q)) begin
            state_d = ST_X_SETUP;
            aer_d   = {ev_x_ext_c, ev_polarity};
            xsel_d  = 1'b1;
          end else begin
            state_d = ST_Y_SETUP;
            aer_d   = {1'b0, ev_y_ext_c};
            xsel_d  = 1'b0;
          end
        end else if (idle_cnt_q < IDLE_W'(IDLE_N)) begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          if (idle_cnt_q == IDLE_W'(IDLE_N - 1)) begin
            row_valid_d = 1'b0;
          end
        end
      end

      ST_Y_SETUP, ST_X_SETUP: begin
        if (setup_cnt_q == SETUP_W'(SETUP_N - 1)) begin
          state_d = (state_q == ST_Y_SETUP) ? ST_Y_REQ : ST_X_REQ;
          req_d   = 1'b1;
        end else begin
          setup_cnt_d = setup_cnt_q + SETUP_W'(1);
        end
      end

      ST_Y_REQ, ST_X_REQ: begin
        if (ack_s_q) begin
          state_d = (state_q == ST_Y_REQ) ? ST_Y_REL : ST_X_REL;
          req_d   = 1'b0;
        end
      end

      ST_Y_REL: begin
        if (!ack_s_q) begin
          state_d     = ST_X_SETUP;
          aer_d       = {x_q, pol_q};
          xsel_d      = 1'b1;
          setup_cnt_d = '0;
          last_y_d    = y_q;
          row_valid_d = 1'b1;
        end
      end

      ST_X_REL: begin
        if (!ack_s_q) begin
          state_d = ST_PACE;
        end
      end

      ST_PACE: begin
        if (pace_cnt_q >= PACE_W'(PACE_EXIT)) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase

    ev_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State, output and ack-synchronizer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      aer_q       <= '0;
      xsel_q      <= 1'b0;
      req_q       <= 1'b0;
      ev_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      pol_q       <= 1'b0;
      last_y_q    <= '0;
      row_valid_q <= 1'b0;
      setup_cnt_q <= '0;
      pace_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      ack_meta_q  <= 1'b0;
      ack_s_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      aer_q       <= aer_d;
      xsel_q      <= xsel_d;
      req_q       <= req_d;
      ev_ready_q  <= ev_ready_d;
      busy_q      <= busy_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pol_q       <= pol_d;
      last_y_q    <= last_y_d;
      row_valid_q <= row_valid_d;
      setup_cnt_q <= setup_cnt_d;
      pace_cnt_q  <= pace_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      ack_meta_q  <= ack;
      ack_s_q     <= ack_meta_q;
    end
  end

  assign aer      = aer_q;
  assign xsel     = xsel_q;
  assign req      = req_q;
  assign ev_ready = ev_ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dvs_aer_transmitter.sv
// tb_dvs_aer_transmitter: randomized and directed stimulus for
// dvs_aer_transmitter. The expected AER word stream comes from an
// event-level model of row suppression and row timeout.
module tb_dvs_aer_transmitter;

  localparam int MIN_EV = 9;
  localparam int SETUP  = 1;
  localparam int TO     = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ev_valid;
  logic       ev_ready;
  logic [8:0] ev_x;
  logic [8:0] ev_y;
  logic       ev_polarity;
  logic [9:0] aer;
  logic       xsel;
  logic       req;
  logic       ack;
  logic       busy;

  logic imm = 1'b0;     // 1: ack follows req combinationally
  logic ack_r = 1'b0;
  assign ack = imm ? req : ack_r;

  dvs_aer_transmitter #(
    .DVS_X_ADDR_BITS   (9),
    .DVS_Y_ADDR_BITS   (9),
    .MIN_EVENT_CYCLES  (MIN_EV),
    .SETUP_CYCLES      (SETUP),
    .ROW_TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_x       (ev_x),
    .ev_y       (ev_y),
    .ev_polarity(ev_polarity),
    .aer        (aer),
    .xsel       (xsel),
    .req        (req),
    .ack        (ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  // ---------------- event-level reference model ----------------
  typedef struct {
    logic [9:0] aer;
    logic       xsel;
    int         acc;
    bit         first;
  } word_t;

  word_t exp_q[$];
  bit    m_row_valid = 0;
  int    m_last_y    = 0;
  int    m_idle      = 0;
  bit    m_have_prev = 0;
  int    m_prev_acc  = 0;
  int    m_last_gap  = 0;
  bit    accepted    = 0;
  int    acc_edge    = 0;

  task automatic model_reset();
    exp_q.delete();
    m_row_valid = 0;
    m_idle      = 0;
    m_have_prev = 0;
  endtask

  // Called at the negedge before an accepting edge.
  task automatic model_accept();
    int    e;
    int    xv;
    bit    new_row;
    word_t w;
    e  = cyc + 1;
    xv = int'(ev_x);
    new_row = !(m_row_valid && (m_idle < TO) && (m_last_y == int'(ev_y)));
    if (m_have_prev) begin
      m_last_gap = e - m_prev_acc;
      check("pace_min", 32'(m_last_gap >= MIN_EV), 1);
    end
    if (new_row) begin
      w.aer = 10'(int'(ev_y)); w.xsel = 1'b0; w.acc = e; w.first = 1'b1;
      exp_q.push_back(w);
      m_row_valid = 1;
      m_last_y    = int'(ev_y);
    end
    w.aer = 10'(xv * 2 + int'(ev_polarity)); w.xsel = 1'b1; w.acc = e; w.first = !new_row;
    exp_q.push_back(w);
    m_idle      = 0;
    m_have_prev = 1;
    m_prev_acc  = e;
    accepted    = 1;
    acc_edge    = e;
  endtask

  // Account for the upcoming edge, then advance to the next negedge.
  task automatic tick();
    if (rst_n) begin
      if (ev_valid && ev_ready) model_accept();
      else if (ev_ready) m_idle++;
    end
    @(negedge clk);
  endtask

  task automatic send(input int x, input int y, input bit p);
    int n;
    n = 0;
    ev_x = 9'(x); ev_y = 9'(y); ev_polarity = p;
    ev_valid = 1'b1;
    accepted = 0;
    while (!accepted && n < 3000) begin
      tick();
      n++;
    end
    ev_valid = 1'b0;
    check("accepted", 32'(accepted), 1);
    check("busy_after_acc", 32'(busy), 1);
    check("ready_after_acc", 32'(ev_ready), 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!ev_ready && n < 3000) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(ev_ready), 1);
    check("busy_idle", 32'(busy), 0);
    check("words_done", 32'(exp_q.size()), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- AER responder ----------------
  int ph = 0, rcnt = 0, dly = 2, hold = 2;
  int ack_rise_edge = 0, ack_fall_edge = 0;

  always begin
    @(negedge clk);
    if (!rst_n || imm) begin
      ack_r = 1'b0;
      ph    = 0;
    end else begin
      if (ph == 0 && req) begin rcnt = 0; ph = 1; end
      if (ph == 1) begin
        if (rcnt >= dly) begin ack_r = 1'b1; ack_rise_edge = cyc + 1; ph = 2; end
        else rcnt++;
      end else if (ph == 2) begin
        if (!req) begin rcnt = 0; ph = 3; end
      end
      if (ph == 3) begin
        if (rcnt >= hold) begin ack_r = 1'b0; ack_fall_edge = cyc + 1; ph = 0; end
        else rcnt++;
      end
    end
  end

  // ---------------- bus monitor ----------------
  logic       req_p = 0, xsel_p = 0;
  logic [9:0] aer_p = '0, rise_aer = '0;
  logic       rise_xsel = 0;
  int         stable = 0;
  bit         viol = 0;
  word_t      mw;

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      req_p = 0; xsel_p = 0; aer_p = '0; stable = 0; viol = 0;
    end else begin
      if ((aer !== aer_p) || (xsel !== xsel_p)) begin
        if (req_p || req || ack) viol = 1;
        if (xsel && !xsel_p && !imm) check("x_setup_edge", 32'(cyc), 32'(ack_fall_edge + 2));
        stable = 0;
      end else begin
        stable++;
      end
      if (req && !req_p) begin
        if (ack && !imm) viol = 1;
        check("setup_stable", 32'(stable >= SETUP), 1);
        if (exp_q.size() == 0) begin
          check("extra_word", 32'(exp_q.size()), 1);
        end else begin
          mw = exp_q.pop_front();
          check("aer", 32'(aer), 32'(mw.aer));
          check("xsel", 32'(xsel), 32'(mw.xsel));
          if (mw.first) check("setup_lat", 32'(cyc - mw.acc), SETUP);
        end
        rise_aer  = aer;
        rise_xsel = xsel;
      end
      if (!req && req_p) begin
        check("word_hold", 32'({xsel, aer}), 32'({rise_xsel, rise_aer}));
        if (!imm) check("req_fall_edge", 32'(cyc), 32'(ack_rise_edge + 2));
        check("stable_hs", 32'(viol), 0);
        viol = 0;
      end
      req_p  = req;
      aer_p  = aer;
      xsel_p = xsel;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int rel;
    int n;
    int r;
    int y;

    rst_n = 1'b0;
    ev_valid = 1'b1; ev_x = 9'd100; ev_y = 9'd50; ev_polarity = 1'b1;
    imm = 1'b0; dly = 2; hold = 2;
    repeat (3) @(negedge clk);
    #1;
    check("rst_aer", 32'(aer), 0);
    check("rst_xsel", 32'(xsel), 0);
    check("rst_req", 32'(req), 0);
    check("rst_ready", 32'(ev_ready), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc + 1;

    // x=100 y=50 pol=1: Y 0x032 then X 0x0C9; first accept on 2nd edge.
    send(100, 50, 1);
    check("first_acc", 32'(acc_edge), 32'(rel + 1));
    // Same row back-to-back: X word 0x00F only.
    send(7, 50, 1);
    wait_idle();

    // Row timeout boundary.
    idle(TO - 1);
    send(9, 50, 0);
    wait_idle();
    idle(TO);
    send(11, 50, 1);
    wait_idle();

    // Slow responder.
    dly = 50; hold = 20;
    send(300, 400, 0);
    wait_idle();

    // Pacing with ev_valid held high and an immediate responder.
    imm = 1'b1;
    send(1, 20, 1);
    for (int k = 0; k < 4; k++) begin
      send(k + 2, 20, k[0]);
      if (k > 0) check("pace_exact", 32'(m_last_gap), MIN_EV);
    end
    wait_idle();

    // Reset during X_REQ.
    imm = 1'b0; dly = 10; hold = 1;
    send(33, 250, 1);
    n = 0;
    while (!(req && xsel) && n < 500) begin
      tick();
      n++;
    end
    check("reached_x_req", 32'(req && xsel), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(req), 0);
    check("mid_rst_aer", 32'(aer), 0);
    check("mid_rst_xsel", 32'(xsel), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(34, 250, 0);
    wait_idle();

    // Randomized bursts.
    y = 50;
    for (int b = 0; b < 40; b++) begin
      imm = ($urandom_range(0, 2) == 0);
      dly = $urandom_range(0, 4);
      hold = $urandom_range(0, 4);
      n = $urandom_range(1, 3);
      for (int e = 0; e < n; e++) begin
        if ($urandom_range(0, 2) == 0) y = $urandom_range(0, 511);
        send($urandom_range(0, 511), y, 1'($urandom_range(0, 1)));
      end
      wait_idle();
      r = $urandom_range(0, 9);
      if (r < 6)       idle($urandom_range(0, 5));
      else if (r == 6) idle(TO - 1);
      else if (r == 7) idle(TO);
      else if (r == 8) idle(TO + 3);
    end

    wait_idle();
    repeat (3) tick();
    check("final_stable", 32'(viol), 0);
    check("final_queue", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvs_aer_transmitter.md
# dvs_aer_transmitter

Synthesizable AER sender that emulates the DVS camera side of the AER link. It accepts pixel events over a valid/ready interface and drives them onto the 10-bit AER bus as a Y-address word followed by an X-address word, each under a 4-phase REQ/ACK handshake. It sits opposite `dvs_aer_receiver`, in loopback/emulation builds and in hardware self-test. It suppresses the Y word when the row is unchanged, and it enforces a minimum event period matching DVS readout.

## Interface
Parameters:
- `MIN_EVENT_CYCLES`, default 9: minimum clock cycles between successive event accepts (≥ 83.3 ns at the default clock).
- `SETUP_CYCLES`, default 1: cycles that AER data/`xsel` are stable before `req` rises (≥1).
- `ROW_TIMEOUT_CYCLES`, default 100: consecutive idle cycles after which the remembered row is invalidated.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ev_valid`  in  1  event offered.
- `ev_ready`  out  1  event accepted on an edge where `ev_valid && ev_ready`.
- `ev_x`  in  `DVS_X_ADDR_BITS`  pixel X (dvs_ravens_pkg); zero-extended to 9 bits.
- `ev_y`  in  `DVS_Y_ADDR_BITS`  pixel Y; zero-extended to 9 bits.
- `ev_polarity`  in  1  event polarity.
- `aer`  out  10  AER data bus.
- `xsel`  out  1  0 = Y word, 1 = X word.
- `req`  out  1  AER request.
- `ack`  in  1  AER acknowledge; asynchronous, passes through a 2-flop synchronizer to give `ack_s`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Word formats:
  - Y word: `aer = {1'b0, y[8:0]}`, `xsel = 0`.
  - X word: `aer = {x[8:0], polarity}`, `xsel = 1`.
- Event fields are latched on accept. Outputs are sourced from the latches only.
- All outputs are registered. Reset values: `aer = 0`, `xsel = 0`, `req = 0`, `ev_ready = 0`, `busy = 0`. Internal `row_valid = 0`, `last_y = 0`, counters = 0.
- `ev_ready` is registered as `next_state == IDLE`.
- FSM states: IDLE, Y_SETUP, Y_REQ, Y_REL, X_SETUP, X_REQ, X_REL, PACE.
  - IDLE: on accept, if `row_valid && ev_y == last_y` go to X_SETUP, else go to Y_SETUP. The period counter restarts on accept.
  - Y_SETUP / X_SETUP: drive the word with `req = 0`, hold for `SETUP_CYCLES`, then go to the REQ state with `req <= 1`.
  - Y_REQ / X_REQ: hold `req = 1` and the data until `ack_s = 1`, then `req <= 0` and go to the REL state.
  - Y_REL: wait for `ack_s = 0`, then go to X_SETUP. On this exit, `last_y <= y` and `row_valid <= 1`.
  - X_REL: wait for `ack_s = 0`, then go to PACE.
  - PACE: leave for IDLE once the period counter allows the next accept edge at no less than accept + `MIN_EVENT_CYCLES`. If the handshake already took longer, exit to IDLE immediately.
- `aer` and `xsel` change only in SETUP states, never while `req = 1` or while `ack_s = 1`.
- Row timeout:
  - The idle counter increments each cycle in IDLE without accept and clears on accept. It saturates at `ROW_TIMEOUT_CYCLES`.
  - When the counter reaches `ROW_TIMEOUT_CYCLES`, `row_valid <= 0`.
- There is no ACK timeout: the FSM waits indefinitely in REQ/REL states.

## Timing
- Accept edge E0: `aer`/`xsel` valid at E0 (SETUP state entered). `req` rises at E0 + `SETUP_CYCLES`.
- `ack` rising between edges: `ack_s` is high after 2 edges. `req` falls on the 3rd rising edge after the `ack` transition. The same 3-edge rule applies to `ack` falling and the next SETUP entry.
- With an immediate responder (ack follows req combinationally), each word takes `SETUP_CYCLES` + 6 cycles.
- A new-row event therefore takes 14 cycles and a same-row event 7 cycles at defaults. A same-row event is then extended by PACE to 9.
- Reset mid-operation: reset is asynchronous. `req`, `aer` and `xsel` go to 0 immediately. The in-flight event is discarded, `row_valid` clears, and the synchronizer clears.
- `ev_valid` asserted during reset is not accepted. The first accept is possible at the 2nd edge after `rst_n` rises.

## Test plan
- Single event x=100, y=50, pol=1, responder acking after 2 cycles -> Y word `aer=0x032 xsel=0`, then X word `aer=0x0C9 xsel=1`. Each word is stable through its handshake, and `req` never rises before data has been stable for `SETUP_CYCLES`.
- Two events y=50 (x=100, then x=7), back-to-back -> the second produces only an X word `aer=0x00F`, with no `xsel=0` handshake.
- Row timeout -> idle exactly `ROW_TIMEOUT_CYCLES` before a same-row event resends the Y word. Idle `ROW_TIMEOUT_CYCLES-1` does not.
- Slow responder:
  - `ack` delayed 50 cycles -> `req` is held high with `aer` unchanged for the whole wait.
  - `ack` then held high 20 cycles -> `req` stays low and no SETUP is entered until `ack` falls.
- Reset asserted in X_REQ -> `req`, `aer` and `xsel` are 0 immediately. After release, a same-row event sends the Y word again.
- `ev_valid` held high with y constant and an immediate responder -> accept edges are exactly `MIN_EVENT_CYCLES` = 9 cycles apart.
